// File: rtl/lamp_bus_arbiter.sv
// Round-robin arbiter that runs single-byte lamp-card bus cycles for two requesters
// (UART command path and background poll scheduler) through setup/strobe/hold phases.
module lamp_bus_arbiter #(
    parameter int SETUP_CYCLES  = 3,
    parameter int STROBE_CYCLES = 8,
    parameter int HOLD_CYCLES   = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_write,
    input  logic [3:0] req0_board,
    input  logic [2:0] req0_addr,
    input  logic [7:0] req0_wdata,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_write,
    input  logic [3:0] req1_board,
    input  logic [2:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic [3:0] BOARD_X,
    output logic [2:0] AddessPortPin,
    output logic       RdP,
    output logic       WrP,
    output logic       data_dir,
    output logic [7:0] Data_Out_Port,
    input  logic [7:0] Data_In_Port,
    output logic [1:0] dbg_state
);

    localparam int SETUP_EFF  = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
    localparam int STROBE_EFF = (STROBE_CYCLES < 1) ? 1 : STROBE_CYCLES;
    localparam int HOLD_EFF   = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;

    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_EFF - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_EFF - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_EFF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       last_grant;
    logic       armed;
    logic       lat_write;
    logic       lat_id;
    logic       grant0, grant1, accept, phase_done;
    logic       sel_write;
    logic [3:0] sel_board;
    logic [2:0] sel_addr;
    logic [7:0] sel_wdata;

    // Handshake: a request transfers on a clock edge where reqN_valid and reqN_ready are
    // both high; ready is only offered in IDLE, to at most one port, and never during reset.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = armed & (state == IDLE) & grant0;
        req1_ready = armed & (state == IDLE) & grant1;
        accept     = req0_ready | req1_ready;
        phase_done = (cnt == 8'd0);

        sel_write = req0_write;
        sel_board = req0_board;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        if (grant1) begin
            sel_write = req1_write;
            sel_board = req1_board;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LAST;
                end
            end
            SETUP: begin
                if (phase_done) begin
                    state_next = STROBE;
                    cnt_next   = STROBE_LAST;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            STROBE: begin
                if (phase_done) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LAST;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (phase_done) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // armed keeps both readys low while reset is asserted, even if a valid is already up.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Pin outputs are updated one edge ahead of the phase they belong to, so the
    // strobe edges never coincide with a change of address, board or direction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant    <= 1'b1;
            lat_write     <= 1'b0;
            lat_id        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_rdata     <= 8'd0;
            busy          <= 1'b0;
            BOARD_X       <= 4'd0;
            AddessPortPin <= 3'd0;
            Data_Out_Port <= 8'd0;
            data_dir      <= 1'b0;
            RdP           <= 1'b1;
            WrP           <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            busy      <= (state_next != IDLE);
            if (accept) begin
                last_grant    <= grant1;
                lat_id        <= grant1;
                lat_write     <= sel_write;
                BOARD_X       <= sel_board;
                AddessPortPin <= sel_addr;
                Data_Out_Port <= sel_wdata;
                data_dir      <= sel_write;
            end
            if ((state == SETUP) && phase_done) begin
                WrP <= ~lat_write;
                RdP <= lat_write;
            end
            if ((state == STROBE) && phase_done) begin
                WrP <= 1'b1;
                RdP <= 1'b1;
                if (!lat_write) begin
                    rsp_rdata <= Data_In_Port;
                end
            end
            if ((state == HOLD) && phase_done) begin
                data_dir  <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_id    <= lat_id;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_lamp_bus_arbiter.sv
// Bench for lamp_bus_arbiter: a timeline model of bus cycles checked every cycle,
// plus literal per-cycle expectations for the directed scenarios.
module tb_lamp_bus_arbiter;

    localparam int S   = 2;
    localparam int P   = 4;
    localparam int H   = 2;
    localparam int TOT = S + P + H;

    localparam int SIG_READY0 = 0;
    localparam int SIG_READY1 = 1;
    localparam int SIG_RSPV   = 2;
    localparam int SIG_RSPID  = 3;
    localparam int SIG_RDATA  = 4;
    localparam int SIG_RDP    = 5;
    localparam int SIG_WRP    = 6;
    localparam int SIG_DDIR   = 7;
    localparam int SIG_DOUT   = 8;
    localparam int SIG_BUSY   = 9;
    localparam int SIG_BOARD  = 10;
    localparam int SIG_B_RDY0 = 11;
    localparam int SIG_B_RSPV = 12;
    localparam int SIG_B_WRP  = 13;

    // clock / reset
    logic       clock = 1'b0;
    logic       reset_n;
    int         cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // DUT signals
    logic       req0_valid, req0_ready, req0_write;
    logic [3:0] req0_board;
    logic [2:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       req1_valid, req1_ready, req1_write;
    logic [3:0] req1_board;
    logic [2:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       rsp_valid, rsp_id, busy, RdP, WrP, data_dir;
    logic [7:0] rsp_rdata, Data_Out_Port, Data_In_Port;
    logic [3:0] BOARD_X;
    logic [2:0] AddessPortPin;
    logic [1:0] dbg_state;

    // second instance with all phase lengths set to 0
    logic       b_req0_valid, b_req1_valid;
    logic       b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_busy;
    logic       b_RdP, b_WrP, b_data_dir;
    logic [7:0] b_rsp_rdata, b_Data_Out_Port;
    logic [3:0] b_BOARD_X;
    logic [2:0] b_AddessPortPin;
    logic [1:0] b_dbg_state;

    lamp_bus_arbiter #(.SETUP_CYCLES(S), .STROBE_CYCLES(P), .HOLD_CYCLES(H)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_board(req0_board), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_board(req1_board), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .busy(busy),
        .BOARD_X(BOARD_X), .AddessPortPin(AddessPortPin), .RdP(RdP), .WrP(WrP),
        .data_dir(data_dir), .Data_Out_Port(Data_Out_Port), .Data_In_Port(Data_In_Port),
        .dbg_state(dbg_state)
    );

    lamp_bus_arbiter #(.SETUP_CYCLES(0), .STROBE_CYCLES(0), .HOLD_CYCLES(0)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_write(req0_write),
        .req0_board(req0_board), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_write(req1_write),
        .req1_board(req1_board), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
        .BOARD_X(b_BOARD_X), .AddessPortPin(b_AddessPortPin), .RdP(b_RdP), .WrP(b_WrP),
        .data_dir(b_data_dir), .Data_Out_Port(b_Data_Out_Port), .Data_In_Port(Data_In_Port),
        .dbg_state(b_dbg_state)
    );

    // literal expectations: (cycle, signal, value)
    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } lit_t;
    lit_t lit_q[$];
    int   lit_hits = 0;
    logic tb_done  = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    // model of the bus: one transaction at a time, placed on a cycle timeline
    logic        m_act;
    int          m_t0;
    logic        m_last, m_write, m_id;
    logic [3:0]  m_board;
    logic [2:0]  m_addr;
    logic [7:0]  m_wdata, m_rdata;

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            SIG_READY0: sig_val = 32'(req0_ready);
            SIG_READY1: sig_val = 32'(req1_ready);
            SIG_RSPV:   sig_val = 32'(rsp_valid);
            SIG_RSPID:  sig_val = 32'(rsp_id);
            SIG_RDATA:  sig_val = 32'(rsp_rdata);
            SIG_RDP:    sig_val = 32'(RdP);
            SIG_WRP:    sig_val = 32'(WrP);
            SIG_DDIR:   sig_val = 32'(data_dir);
            SIG_DOUT:   sig_val = 32'(Data_Out_Port);
            SIG_BUSY:   sig_val = 32'(busy);
            SIG_BOARD:  sig_val = 32'(BOARD_X);
            SIG_B_RDY0: sig_val = 32'(b_req0_ready);
            SIG_B_RSPV: sig_val = 32'(b_rsp_valid);
            SIG_B_WRP:  sig_val = 32'(b_WrP);
            default:    sig_val = 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            SIG_READY0: sig_name = "req0_ready";
            SIG_READY1: sig_name = "req1_ready";
            SIG_RSPV:   sig_name = "rsp_valid";
            SIG_RSPID:  sig_name = "rsp_id";
            SIG_RDATA:  sig_name = "rsp_rdata";
            SIG_RDP:    sig_name = "RdP";
            SIG_WRP:    sig_name = "WrP";
            SIG_DDIR:   sig_name = "data_dir";
            SIG_DOUT:   sig_name = "Data_Out_Port";
            SIG_BUSY:   sig_name = "busy";
            SIG_BOARD:  sig_name = "BOARD_X";
            SIG_B_RDY0: sig_name = "b_req0_ready";
            SIG_B_RSPV: sig_name = "b_rsp_valid";
            SIG_B_WRP:  sig_name = "b_WrP";
            default:    sig_name = "unknown";
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got 'h%0h, want 'h%0h", nm, cyc, act, exp);
        end
    endtask

    // compare process: model outputs every cycle, then literal expectations
    always @(negedge clock) begin
        int   k;
        logic in_bus, strb, rsp, idle, g0, g1;
        if (!reset_n) begin
            m_act   = 1'b0;
            m_t0    = 0;
            m_last  = 1'b1;
            m_write = 1'b0;
            m_id    = 1'b0;
            m_board = 4'd0;
            m_addr  = 3'd0;
            m_wdata = 8'd0;
            m_rdata = 8'd0;
        end
        k      = m_act ? (cyc - m_t0) : 1000;
        in_bus = reset_n && (k >= 1) && (k <= TOT);
        strb   = in_bus && (k > S) && (k <= S + P);
        rsp    = reset_n && (k == TOT + 1);
        idle   = reset_n && !in_bus;
        g0     = idle && req0_valid && (!req1_valid || m_last);
        g1     = idle && req1_valid && (!req0_valid || !m_last);

        chk("ready0", 32'(req0_ready), 32'(g0));
        chk("ready1", 32'(req1_ready), 32'(g1));
        chk("busy", 32'(busy), 32'(in_bus));
        chk("rsp_valid", 32'(rsp_valid), 32'(rsp));
        if (rsp) chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        chk("board", 32'(BOARD_X), 32'(m_board));
        chk("addr", 32'(AddessPortPin), 32'(m_addr));
        chk("dout", 32'(Data_Out_Port), 32'(m_wdata));
        chk("data_dir", 32'(data_dir), 32'(in_bus && m_write));
        chk("RdP", 32'(RdP), 32'(!(strb && !m_write)));
        chk("WrP", 32'(WrP), 32'(!(strb && m_write)));

        foreach (lit_q[i]) begin
            if (lit_q[i].cyc == cyc) begin
                chk({"lit_", sig_name(lit_q[i].sig)}, sig_val(lit_q[i].sig), lit_q[i].val);
                lit_hits++;
            end
        end

        if (reset_n) begin
            if (strb && (k == S + P) && !m_write) m_rdata = Data_In_Port;
            if (g0 || g1) begin
                m_act   = 1'b1;
                m_t0    = cyc;
                m_id    = g1;
                m_last  = g1;
                m_write = g1 ? req1_write : req0_write;
                m_board = g1 ? req1_board : req0_board;
                m_addr  = g1 ? req1_addr  : req0_addr;
                m_wdata = g1 ? req1_wdata : req0_wdata;
            end
        end

        if (tb_done) begin
            chk("lit_all_seen", 32'(lit_hits), 32'(lit_q.size()));
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_at(input int c, input int s, input logic [31:0] v);
        lit_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        lit_q.push_back(e);
    endtask

    initial begin
        int t;
        reset_n      = 1'b0;
        req0_valid   = 1'b0; req0_write = 1'b0; req0_board = 4'd0; req0_addr = 3'd0; req0_wdata = 8'd0;
        req1_valid   = 1'b0; req1_write = 1'b0; req1_board = 4'd0; req1_addr = 3'd0; req1_wdata = 8'd0;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0;
        Data_In_Port = 8'd0;

        // reset values
        next_cycle();
        t = cyc;
        expect_at(t, SIG_RSPV, 0);  expect_at(t, SIG_RSPID, 0); expect_at(t, SIG_RDATA, 0);
        expect_at(t, SIG_BOARD, 0); expect_at(t, SIG_RDP, 1);   expect_at(t, SIG_WRP, 1);
        expect_at(t, SIG_DDIR, 0);  expect_at(t, SIG_DOUT, 0);  expect_at(t, SIG_BUSY, 0);
        next_cycle();
        reset_n = 1'b1;
        repeat (2) next_cycle();

        // port 0 write, board 3 addr 5 data A5
        t = cyc;
        req0_valid = 1'b1; req0_write = 1'b1; req0_board = 4'h3; req0_addr = 3'h5; req0_wdata = 8'hA5;
        Data_In_Port = 8'hEE;
        expect_at(t, SIG_READY0, 1);   expect_at(t, SIG_READY1, 0);
        expect_at(t + 1, SIG_DDIR, 1); expect_at(t + 1, SIG_DOUT, 8'hA5); expect_at(t + 2, SIG_DDIR, 1);
        expect_at(t + 2, SIG_WRP, 1);  expect_at(t + 3, SIG_WRP, 0); expect_at(t + 6, SIG_WRP, 0);
        expect_at(t + 7, SIG_WRP, 1);  expect_at(t + 3, SIG_RDP, 1); expect_at(t + 6, SIG_RDP, 1);
        expect_at(t + 4, SIG_DOUT, 8'hA5);
        expect_at(t + 9, SIG_RSPV, 1); expect_at(t + 9, SIG_RSPID, 0); expect_at(t + 10, SIG_RSPV, 0);
        next_cycle();
        req0_valid = 1'b0; req0_wdata = 8'h00;
        repeat (9) next_cycle();

        // port 1 read, board 1 addr 2, pins present 3C
        t = cyc;
        req1_valid = 1'b1; req1_write = 1'b0; req1_board = 4'h1; req1_addr = 3'h2; req1_wdata = 8'h99;
        Data_In_Port = 8'h3C;
        expect_at(t, SIG_READY1, 1);  expect_at(t, SIG_READY0, 0);
        expect_at(t + 3, SIG_RDP, 0); expect_at(t + 6, SIG_RDP, 0); expect_at(t + 7, SIG_RDP, 1);
        expect_at(t + 4, SIG_WRP, 1);
        expect_at(t + 1, SIG_DDIR, 0); expect_at(t + 4, SIG_DDIR, 0); expect_at(t + 8, SIG_DDIR, 0);
        expect_at(t + 9, SIG_RSPV, 1); expect_at(t + 9, SIG_RSPID, 1); expect_at(t + 9, SIG_RDATA, 8'h3C);
        next_cycle();
        req1_valid = 1'b0;
        repeat (9) next_cycle();

        // both valid continuously: grants 0,1,0,1 nine cycles apart
        t = cyc;
        req0_valid = 1'b1; req0_write = 1'b1; req0_board = 4'h8; req0_addr = 3'h1; req0_wdata = 8'h11;
        req1_valid = 1'b1; req1_write = 1'b0; req1_board = 4'h9; req1_addr = 3'h6;
        expect_at(t, SIG_READY0, 1);      expect_at(t, SIG_READY1, 0);
        expect_at(t + 9, SIG_READY1, 1);  expect_at(t + 9, SIG_READY0, 0);
        expect_at(t + 18, SIG_READY0, 1); expect_at(t + 18, SIG_READY1, 0);
        expect_at(t + 27, SIG_READY1, 1); expect_at(t + 27, SIG_READY0, 0);
        expect_at(t + 9, SIG_RSPID, 0);
        expect_at(t + 18, SIG_RSPID, 1);  expect_at(t + 18, SIG_RDATA, 8'h4F);
        expect_at(t + 19, SIG_DOUT, 8'h22);
        expect_at(t + 36, SIG_RSPV, 1);   expect_at(t + 36, SIG_RDATA, 8'h61);
        for (int i = 0; i < 36; i++) begin
            Data_In_Port = 8'h40 + 8'(i);
            next_cycle();
            if (i == 0) req0_wdata = 8'h22;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        next_cycle();

        // only port 0 valid: back-to-back grants, each in its rsp_valid cycle
        t = cyc;
        req0_valid = 1'b1; req0_write = 1'b1; req0_board = 4'h2; req0_addr = 3'h7; req0_wdata = 8'h5C;
        expect_at(t, SIG_READY0, 1);      expect_at(t + 1, SIG_READY0, 0);
        expect_at(t + 9, SIG_READY0, 1);  expect_at(t + 9, SIG_RSPV, 1);  expect_at(t + 9, SIG_RSPID, 0);
        expect_at(t + 18, SIG_READY0, 1); expect_at(t + 18, SIG_RSPV, 1); expect_at(t + 18, SIG_RSPID, 0);
        repeat (19) next_cycle();
        req0_valid = 1'b0;
        repeat (9) next_cycle();

        // reset during cycle T+4 of a write, then a tie goes to port 0
        t = cyc;
        req0_valid = 1'b1; req0_write = 1'b1; req0_board = 4'h6; req0_addr = 3'h3; req0_wdata = 8'hC3;
        expect_at(t, SIG_READY0, 1); expect_at(t + 3, SIG_WRP, 0); expect_at(t + 3, SIG_DDIR, 1);
        expect_at(t + 4, SIG_WRP, 1); expect_at(t + 4, SIG_DDIR, 0); expect_at(t + 4, SIG_BUSY, 0);
        expect_at(t + 4, SIG_RDP, 1);
        expect_at(t + 7, SIG_BOARD, 0);
        expect_at(t + 9, SIG_RSPV, 0); expect_at(t + 10, SIG_RSPV, 0);
        expect_at(t + 12, SIG_READY0, 1); expect_at(t + 12, SIG_READY1, 0);
        next_cycle();
        req0_valid = 1'b0;
        repeat (3) next_cycle();
        #2;
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        repeat (6) next_cycle();
        req0_valid = 1'b1; req1_valid = 1'b1;
        next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (9) next_cycle();

        // zero-length parameters behave as 1/1/1
        t = cyc;
        b_req0_valid = 1'b1; req0_write = 1'b1; req0_board = 4'hA; req0_addr = 3'h4; req0_wdata = 8'h77;
        expect_at(t, SIG_B_RDY0, 1);
        expect_at(t + 1, SIG_B_WRP, 1); expect_at(t + 2, SIG_B_WRP, 0); expect_at(t + 3, SIG_B_WRP, 1);
        expect_at(t + 3, SIG_B_RSPV, 0); expect_at(t + 4, SIG_B_RSPV, 1); expect_at(t + 5, SIG_B_RSPV, 0);
        next_cycle();
        b_req0_valid = 1'b0;
        repeat (6) next_cycle();

        tb_done = 1'b1;
    end

endmodule
